// File: rtl/dm_bus_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dm_bus_bridge_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 access-size encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store strobes, store lane replication and load data alignment.
module dm_lane_align
  import dm_bus_bridge_pkg::*;
(
  input  logic [2:0]      i_f3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata_shifted
);

  // Decode access size into strobes and lane-shifted data; unknown sizes act as a full word.
  always_comb begin
    o_be            = 4'b1111;
    o_wdata         = i_wd;
    o_rdata_shifted = i_rdata;
    case (i_f3)
      F3_B, F3_BU: begin
        o_be            = 4'b0001 << i_off;
        o_wdata         = {4{i_wd[7:0]}};
        o_rdata_shifted = i_rdata >> {i_off, 3'b000};
      end
      F3_H, F3_HU: begin
        // Upper strobe bit falls off for a halfword at offset 3.
        o_be            = 4'b0011 << i_off;
        o_wdata         = {2{i_wd[15:0]}};
        o_rdata_shifted = i_rdata >> {i_off, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// Core data-port to word bus bridge: one outstanding access, registered handshake outputs.
// Optional bus timeout enabled by defining DM_TIMEOUT_EN.
module dm_bus_bridge
  import dm_bus_bridge_pkg::*;
`ifdef DM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_cpu_addr,
  input  logic [XLEN-1:0] i_cpu_wd,
  input  logic [2:0]      i_cpu_f3,
  input  logic            i_cpu_wen,
  input  logic            i_cpu_rd,
  output logic [XLEN-1:0] o_cpu_rdata,
  output logic            o_cpu_ready,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [3:0]      o_bus_be,
  input  logic [XLEN-1:0] i_bus_rdata,
  input  logic            i_bus_ack,
  output logic            o_bus_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic            req_q, req_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] rdata_shifted;

`ifdef DM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  dm_lane_align u_lane_align (
    .i_f3            (f3_q),
    .i_off           (addr_q[1:0]),
    .i_wd            (wd_q),
    .i_rdata         (i_bus_rdata),
    .o_be            (o_bus_be),
    .o_wdata         (o_bus_wdata),
    .o_rdata_shifted (rdata_shifted)
  );

  // Next-state logic for the IDLE -> REQ -> RESP handshake and its registered outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    we_d    = we_q;
    req_d   = req_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
`ifdef DM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        req_d = 1'b0;
        if (i_cpu_wen || i_cpu_rd) begin
          addr_d  = i_cpu_addr;
          wd_d    = i_cpu_wd;
          f3_d    = i_cpu_f3;
          we_d    = i_cpu_wen;
          req_d   = 1'b1;
          state_d = StReq;
`ifdef DM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StReq: begin
        if (i_bus_ack) begin
          if (!we_q) begin
            rdata_d = rdata_shifted;
          end
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = StResp;
`ifdef DM_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          // Abort: complete the access with an error and no load data.
          if (!we_q) begin
            rdata_d = '0;
          end
          req_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        // Core inputs still describe the completing access, so they are not sampled here.
        state_d = StIdle;
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and capture registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef DM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
`ifdef DM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_cpu_rdata = rdata_q;
  assign o_cpu_ready = ready_q;
  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = {addr_q[XLEN-1:2], 2'b00};
`ifdef DM_TIMEOUT_EN
  assign o_bus_err   = err_q;
`else
  assign o_bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Self-checking bench for dm_bus_bridge: transaction-level model plus directed literal checks.
module tb_dm_bus_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [2:0]  cpu_f3;
  logic        cpu_wen;
  logic        cpu_rd;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

`ifdef DM_TIMEOUT_EN
  localparam int TO = 4;
  dm_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
`else
  dm_bus_bridge dut (
`endif
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wd    (cpu_wd),
    .i_cpu_f3    (cpu_f3),
    .i_cpu_wen   (cpu_wen),
    .i_cpu_rd    (cpu_rd),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ready (cpu_ready),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .o_bus_be    (bus_be),
    .i_bus_rdata (bus_rdata),
    .i_bus_ack   (bus_ack),
    .o_bus_err   (bus_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (size arithmetic, transaction flags) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    int m;
    if (nbytes(f3) == 4) return 4'hF;
    m = ((1 << nbytes(f3)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    logic [31:0] b;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      b = (wd >> (8 * (k % nbytes(f3)))) & 32'hFF;
      r = r | (b << (8 * k));
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
    if (nbytes(f3) == 4) return rd;
    return rd >> (8 * off);
  endfunction

  bit          m_busy, m_done, m_err, m_we;
  logic [31:0] m_addr, m_wd, m_rdata;
  logic [2:0]  m_f3;
  int          m_wait;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
      m_addr = 0; m_wd = 0; m_rdata = 0; m_f3 = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
      m_err  = 0;
    end else if (m_busy) begin
      if (bus_ack) begin
        if (!m_we) m_rdata = exp_rdata(m_f3, m_addr[1:0], bus_rdata);
        m_busy = 0;
        m_done = 1;
`ifdef DM_TIMEOUT_EN
      end else if (m_wait == TO - 1) begin
        if (!m_we) m_rdata = 0;
        m_busy = 0;
        m_done = 1;
        m_err  = 1;
`endif
      end else begin
        m_wait++;
      end
    end else if (cpu_wen || cpu_rd) begin
      m_addr = cpu_addr; m_wd = cpu_wd; m_f3 = cpu_f3; m_we = cpu_wen;
      m_busy = 1;
      m_wait = 0;
    end
  end

  // Per-cycle comparison of every output against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",   {31'b0, bus_req},   {31'b0, m_busy});
      chk("ready", {31'b0, cpu_ready}, {31'b0, m_done});
      chk("err",   {31'b0, bus_err},   {31'b0, m_err});
      chk("we",    {31'b0, bus_we},    {31'b0, m_we});
      chk("addr",  bus_addr,  m_addr & 32'hFFFF_FFFC);
      chk("be",    {28'b0, bus_be}, {28'b0, exp_be(m_f3, m_addr[1:0])});
      chk("wdata", bus_wdata, exp_wdata(m_f3, m_wd));
      chk("rdata", cpu_rdata, m_rdata);
    end
  end

  int ready_cnt = 0;
  int req_rise  = 0;
  logic req_prev = 0;
  always @(negedge clk) begin
    if (cpu_ready === 1'b1) ready_cnt++;
    if (bus_req === 1'b1 && req_prev !== 1'b1) req_rise++;
    req_prev = bus_req;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access; wait_n idle-ack REQ cycles; checks ready lands at 2+wait_n.
  task automatic run_tr(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
    int cyc;
    cpu_addr = addr; cpu_f3 = f3; cpu_wd = wd; cpu_wen = we; cpu_rd = !we;
    tick();
    cpu_wen = 0; cpu_rd = 0;
    cyc = 1;
    for (int i = 0; i < wait_n; i++) begin
      tick();
      cyc++;
    end
    bus_ack = 1; bus_rdata = rd;
    tick();
    cyc++;
    bus_ack = 0;
    for (int i = 0; i < 4 && cpu_ready !== 1'b1; i++) begin
      tick();
      cyc++;
    end
    chk("ready_latency", cyc, 2 + wait_n);
    tick();
  endtask

  int r0, q0, n;

  initial begin
    rst = 0; cpu_addr = 0; cpu_wd = 0; cpu_f3 = 0; cpu_wen = 0; cpu_rd = 0;
    bus_rdata = 0; bus_ack = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_req",   {31'b0, bus_req},   0);
    chk("rst_ready", {31'b0, cpu_ready}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    rst = 1;
    tick();

    // Store byte at 0x103, two wait states.
    cpu_addr = 32'h103; cpu_f3 = 3'b000; cpu_wd = 32'hAB; cpu_wen = 1;
    tick();
    cpu_wen = 0;
    chk("sb_addr",  bus_addr, 32'h100);
    chk("sb_be",    {28'b0, bus_be}, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hABABABAB);
    tick(); tick();
    bus_ack = 1;
    tick();
    bus_ack = 0;
    chk("sb_ready_cycle4", {31'b0, cpu_ready}, 1);
    tick();

    // Load halfword at 0x202, zero wait.
    cpu_addr = 32'h202; cpu_f3 = 3'b001; cpu_rd = 1;
    tick();
    cpu_rd = 0;
    chk("lh_be", {28'b0, bus_be}, 32'hC);
    bus_ack = 1; bus_rdata = 32'hBEEF1234;
    tick();
    bus_ack = 0;
    chk("lh_ready_cycle2", {31'b0, cpu_ready}, 1);
    chk("lh_rdata", cpu_rdata, 32'h0000BEEF);
    tick();

    // Mixed sizes and offsets through the model.
    run_tr(0, 32'h301, 3'b100, 0, 32'h11223344, 1);
    chk("lbu_rdata", cpu_rdata, 32'h00112233);
    run_tr(1, 32'h306, 3'b001, 32'hFFFF5AA5, 0, 0);
    run_tr(0, 32'h307, 3'b101, 0, 32'hCAFEF00D, 3);
    chk("lhu_off3_rdata", cpu_rdata, 32'h000000CA);

    // Back-to-back: load word then store word in the cycle after RESP.
    r0 = ready_cnt; q0 = req_rise;
    run_tr(0, 32'h10, 3'b010, 0, 32'h12345678, 0);
    run_tr(1, 32'h14, 3'b010, 32'hDEADBEEF, 0, 0);
    chk("b2b_ready_pulses", ready_cnt - r0, 2);
    chk("b2b_req_pulses", req_rise - q0, 2);
    chk("b2b_rdata", cpu_rdata, 32'h12345678);

    // Timeout / indefinite wait with no ack.
    cpu_addr = 32'h40; cpu_f3 = 3'b010; cpu_rd = 1;
    tick();
    cpu_rd = 0;
    n = 0;
`ifdef DM_TIMEOUT_EN
    while (bus_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, TO);
    chk("to_err", {31'b0, bus_err}, 1);
    chk("to_ready", {31'b0, cpu_ready}, 1);
    chk("to_rdata", cpu_rdata, 0);
    tick();
`else
    while (bus_req === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("noto_req_held", n, 100);
    chk("noto_err", {31'b0, bus_err}, 0);
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    tick();
    bus_ack = 0;
    chk("noto_ready", {31'b0, cpu_ready}, 1);
    tick();
`endif

    // Stray ack in IDLE.
    r0 = ready_cnt;
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    tick(); tick(); tick();
    bus_ack = 0;
    chk("stray_no_ready", ready_cnt - r0, 0);
    chk("stray_no_req", {31'b0, bus_req}, 0);

    // Reset mid-transaction with a simultaneous ack.
    run_tr(0, 32'h52, 3'b001, 0, 32'hA5A55A5A, 0);
    cpu_addr = 32'h63; cpu_f3 = 3'b000; cpu_wd = 32'h77; cpu_wen = 1;
    tick();
    cpu_wen = 0;
    r0 = ready_cnt;
    bus_ack = 1; bus_rdata = 32'h12121212; rst = 0;
    tick();
    bus_ack = 0;
    chk("rst_mid_req", {31'b0, bus_req}, 0);
    chk("rst_mid_we", {31'b0, bus_we}, 0);
    chk("rst_mid_addr", bus_addr, 0);
    chk("rst_mid_rdata", cpu_rdata, 0);
    rst = 1;
    bus_ack = 1;
    tick(); tick();
    bus_ack = 0;
    chk("rst_mid_no_ready", ready_cnt - r0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
